// File: rtl/turbo_bus_dispatch.sv
// Round-robin dispatcher: locks the upstream bus beat stream to one decoder
// channel for a full turbo packet, then searches onward for the next ready
// channel. Beats are forwarded with one cycle of latency on a shared data bus.
module turbo_bus_dispatch #(
    parameter int BUS           = 534,
    parameter int NUM_CH        = 2,
    parameter int BEATS_PER_PKT = 25,
    parameter int SEL_W         = 4
) (
    input  logic              clk_bus,
    input  logic              rst_n,
    input  logic [BUS-1:0]    bus_data,
    input  logic              bus_en,
    output logic              bus_ready,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] ch_en,
    output logic [BUS-1:0]    ch_data,
    output logic [SEL_W-1:0]  cur_ch,
    output logic [NUM_CH-1:0] pkt_done,
    output logic              proto_err
);

    localparam int               CNT_W     = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_PKT - 1);

    typedef enum logic {SEARCH, XFER} state_t;

    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_ptr, w_ptr_nxt, w_ptr_inc, w_cur_inc;
    logic [SEL_W-1:0]  r_cur_ch;
    logic [CNT_W-1:0]  r_count;
    logic              r_bus_ready, r_proto_err;
    logic [NUM_CH-1:0] r_ch_en, r_pkt_done;
    logic [BUS-1:0]    r_ch_data;
    logic              w_ptr_rdy, w_cur_rdy, w_accept, w_last, w_grant;
    logic [NUM_CH-1:0] w_cur_oh;

    // Look up readiness of the search candidate and the locked channel without
    // indexing by a wider-than-needed select.
    always_comb begin
        w_ptr_rdy = 1'b0;
        w_cur_rdy = 1'b0;
        w_cur_oh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ptr == SEL_W'(i))
                w_ptr_rdy = ch_ready[i];
            if (r_cur_ch == SEL_W'(i)) begin
                w_cur_rdy   = ch_ready[i];
                w_cur_oh[i] = 1'b1;
            end
        end
    end

    assign w_ptr_inc = (r_ptr    == LAST_CH) ? '0 : r_ptr    + 1'b1;
    assign w_cur_inc = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + 1'b1;
    // Any beat in XFER is taken, even with bus_ready low, to absorb ready latency.
    assign w_accept  = (r_state == XFER) && bus_en;
    assign w_last    = w_accept && (r_count == LAST_BEAT);
    assign w_grant   = (r_state == SEARCH) && w_ptr_rdy;

    // State and search pointer registers.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_state <= SEARCH;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next state: one candidate per cycle in SEARCH, release after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            SEARCH: begin
                if (w_ptr_rdy) w_state_nxt = XFER;
                else           w_ptr_nxt   = w_ptr_inc;
            end
            XFER: begin
                if (w_last) begin
                    w_state_nxt = SEARCH;
                    w_ptr_nxt   = w_cur_inc;
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    // Channel lock, beat count, forwarded beat, grant and error flag.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            r_cur_ch    <= '0;
            r_count     <= '0;
            r_bus_ready <= 1'b0;
            r_ch_en     <= '0;
            r_ch_data   <= '0;
            r_pkt_done  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_grant)
                r_cur_ch <= r_ptr;
            if (w_last)
                r_count <= '0;
            else if (w_accept)
                r_count <= r_count + 1'b1;
            r_bus_ready <= (r_state == XFER) && w_cur_rdy && !w_last;
            r_ch_en     <= w_accept ? w_cur_oh : '0;
            r_pkt_done  <= w_last   ? w_cur_oh : '0;
            if (w_accept)
                r_ch_data <= bus_data;
            if ((r_state == SEARCH) && bus_en)
                r_proto_err <= 1'b1;
        end
    end

    assign bus_ready = r_bus_ready;
    assign ch_en     = r_ch_en;
    assign ch_data   = r_ch_data;
    assign cur_ch    = r_cur_ch;
    assign pkt_done  = r_pkt_done;
    assign proto_err = r_proto_err;

endmodule
